// File: rtl/pmem_pkg.sv
// Shared constants and FSM state type for the line-burst memory responder.
package pmem_pkg;

  localparam int WORD_BITS      = 32;
  localparam int LINE_BITS      = 256;
  localparam int BEATS_PER_LINE = 8;
  localparam int OFFSET_BITS    = 5;
  localparam int BEAT_BITS      = $clog2(BEATS_PER_LINE);
  localparam int LINE_IDX_BITS  = WORD_BITS - OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BURST,
    TURN
  } state_t;

endpackage

// File: rtl/pmem_responder_if.sv
// Line-burst memory bus between a cache-side controller and the responder.
interface pmem_responder_if;
  import pmem_pkg::*;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_BITS-1:0] mem_address;
  logic [WORD_BITS-1:0] mem_wdata;
  logic [3:0]           mem_byte_enable;
  logic                 mem_resp;
  logic [WORD_BITS-1:0] mem_rdata;
  logic                 err;

  modport master (
    output mem_read, mem_write, mem_address,
    output mem_wdata, mem_byte_enable,
    input  mem_resp, mem_rdata, err
  );

  modport slave (
    input  mem_read, mem_write, mem_address,
    input  mem_wdata, mem_byte_enable,
    output mem_resp, mem_rdata, err
  );

endinterface

// File: rtl/pmem_word_ram.sv
// Single-port word store: synchronous byte-masked write, asynchronous read.
module pmem_word_ram
  import pmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pmem_responder.sv
// Line-burst memory responder: fixed latency, 8-beat bursts, sticky error.
// Build with PMEM_BYTE_ENABLE_EN to honour mem_byte_enable on writes.
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 4
) (
  input  logic             clk,
  input  logic             rst,
  pmem_responder_if.slave  bus
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_t                   state_q, state_d;
  logic                     op_wr_q, op_wr_d;
  logic [LINE_IDX_BITS-1:0] line_q, line_d;
  logic [3:0]               lat_q, lat_d;
  logic [BEAT_BITS-1:0]     beat_q, beat_d;
  logic                     resp_q, resp_d;
  logic                     err_q, err_d;

  logic                 req_held;
  logic                 ram_we;
  logic [3:0]           ram_be;
  logic [AW-1:0]        ram_addr;
  logic [WORD_BITS-1:0] ram_rdata;
  logic                 unused_bits;

  // Only the latched op's request line keeps the transaction alive.
  assign req_held = op_wr_q ? bus.mem_write : bus.mem_read;

  always_comb begin
    state_d = state_q;
    op_wr_d = op_wr_q;
    line_d  = line_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    resp_d  = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.mem_read && bus.mem_write) begin
          err_d = 1'b1;
        end else if (bus.mem_read || bus.mem_write) begin
          op_wr_d = bus.mem_write;
          line_d  = bus.mem_address[WORD_BITS-1:OFFSET_BITS];
          lat_d   = 4'(LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          err_d   = 1'b1;
          lat_d   = '0;
          state_d = IDLE;
        end else if (lat_q == 4'd0) begin
          beat_d  = '0;
          resp_d  = 1'b1;
          state_d = BURST;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      BURST: begin
        if (!req_held) begin
          err_d   = 1'b1;
          beat_d  = '0;
          state_d = IDLE;
        end else if (beat_q == BEAT_BITS'(BEATS_PER_LINE - 1)) begin
          beat_d  = '0;
          state_d = TURN;
        end else begin
          beat_d = beat_q + BEAT_BITS'(1);
          resp_d = 1'b1;
        end
      end
      TURN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      op_wr_q <= 1'b0;
      line_q  <= '0;
      lat_q   <= '0;
      beat_q  <= '0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      line_q  <= line_d;
      lat_q   <= lat_d;
      beat_q  <= beat_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // A dropped request or reset at the strobe edge suppresses that beat.
  assign ram_we   = rst && resp_q && op_wr_q && bus.mem_write;
  assign ram_addr = AW'({line_q, beat_q});

`ifdef PMEM_BYTE_ENABLE_EN
  assign ram_be      = bus.mem_byte_enable;
  assign unused_bits = ^bus.mem_address[OFFSET_BITS-1:0];
`else
  assign ram_be      = 4'hF;
  assign unused_bits = ^{bus.mem_address[OFFSET_BITS-1:0],
                         bus.mem_byte_enable};
`endif

  pmem_word_ram #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (bus.mem_wdata),
    .rdata (ram_rdata)
  );

  assign bus.mem_resp  = resp_q;
  assign bus.mem_rdata = (resp_q && !op_wr_q) ? ram_rdata : '0;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder: vector table, corner sequences, random traffic.
module tb_pmem_responder;
  import pmem_pkg::*;

  localparam int DEPTH = 1024;
  localparam int LAT   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [31:0] wbuf [8];
  logic [31:0] rbuf [8];
  logic [31:0] ref_mem [DEPTH];

  pmem_responder_if bus ();

  pmem_responder #(
    .DEPTH_WORDS (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] raddr;
    logic [31:0] pre;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_be;
    logic [31:0] exp_full;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a, input int i);
    longint w;
    w = longint'(a >> 5) * 8 + i;
    return int'(w % DEPTH);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = nw;
`ifdef PMEM_BYTE_ENABLE_EN
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? nw[8*b +: 8] : old[8*b +: 8];
    end
`endif
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // cut<8 stops the burst at that beat, by reset (cut_rst) or by dropping the request.
  task automatic run_xact(input bit wr, input logic [31:0] addr,
                          input logic [3:0] be, input int cut,
                          input bit cut_rst);
    int nb;
    int first;
    bit done;
    @(negedge clk);
    bus.mem_read        = !wr;
    bus.mem_write       = wr;
    bus.mem_address     = addr;
    bus.mem_byte_enable = be;
    bus.mem_wdata       = wbuf[0];
    nb    = 0;
    first = -1;
    done  = 1'b0;
    for (int c = 1; c <= LAT + 16 && !done; c++) begin
      @(negedge clk);
      if (bus.mem_resp) begin
        if (first < 0) first = c;
        if (nb == cut) begin
          if (cut_rst) rst = 1'b0;
          else begin
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
          end
          done = 1'b1;
        end else begin
          rbuf[nb] = bus.mem_rdata;
          nb++;
          @(posedge clk);
          #1;
          if (nb < 8) bus.mem_wdata = wbuf[nb];
          else done = 1'b1;
        end
      end
    end
    chk("first_resp_cycle", 32'(first), 32'(LAT + 1));
    chk("beat_count", 32'(nb), 32'(cut < 8 ? cut : 8));
    if (cut < 8) begin
      @(posedge clk);
      #1;
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(negedge clk);
      chk("cut_resp", {31'b0, bus.mem_resp}, 32'd0);
      chk("cut_err", {31'b0, bus.err}, {31'b0, !cut_rst});
      rst = 1'b1;
    end else begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      @(negedge clk);
      chk("turn_resp", {31'b0, bus.mem_resp}, 32'd0);
      chk("turn_rdata", bus.mem_rdata, 32'd0);
    end
    for (int i = 0; i < nb; i++) begin
      if (wr) ref_mem[widx(addr, i)] = merge(ref_mem[widx(addr, i)], wbuf[i], be);
      else chk("read_beat", rbuf[i], ref_mem[widx(addr, i)]);
    end
  endtask

  task automatic fill_wbuf(input logic [31:0] v);
    for (int i = 0; i < 8; i++) wbuf[i] = v;
  endtask

  initial begin
    int seen;
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.mem_address     = '0;
    bus.mem_wdata       = '0;
    bus.mem_byte_enable = '0;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hAABB_CCDD,
                4'b0101, 32'h00BB_00DD, 32'hAABB_CCDD};
    vecs[1] = '{32'h0000_0020, 32'h0000_0020, 32'hFFFF_FFFF, 32'h1234_5678,
                4'b1000, 32'h12FF_FFFF, 32'h1234_5678};
    vecs[2] = '{32'h0000_8000, 32'h0000_0000, 32'h1111_1111, 32'h0000_0000,
                4'b0011, 32'h1111_0000, 32'h0000_0000};
    vecs[3] = '{32'h0000_3FE7, 32'h0000_0FE0, 32'h0F0F_0F0F, 32'hF0F0_F0F0,
                4'b0001, 32'h0F0F_0FF0, 32'hF0F0_F0F0};
    vecs[4] = '{32'h0000_0040, 32'h0000_0040, 32'hCAFE_BABE, 32'hDEAD_BEEF,
                4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[5] = '{32'hFFFF_FFE0, 32'h0000_0FE0, 32'h0000_0000, 32'h5A5A_5A5A,
                4'b0110, 32'h005A_5A00, 32'h5A5A_5A5A};

    @(negedge clk);
    @(negedge clk);
    chk("rst_resp", {31'b0, bus.mem_resp}, 32'd0);
    chk("rst_rdata", bus.mem_rdata, 32'd0);
    chk("rst_err", {31'b0, bus.err}, 32'd0);
    rst = 1'b1;

    // Give every word a known value before any read.
    for (int l = 0; l < DEPTH / 8; l++) begin
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      run_xact(1'b1, 32'(l * 32), 4'hF, 8, 1'b0);
    end

    for (int i = 0; i < 8; i++) wbuf[i] = 32'h1000_0000 + 32'(i);
    run_xact(1'b1, 32'h0000_0040, 4'hF, 8, 1'b0);
    run_xact(1'b0, 32'h0000_0040, 4'h0, 8, 1'b0);
    for (int i = 0; i < 8; i++) chk("line40_beat", rbuf[i], 32'h1000_0000 + 32'(i));
    chk("err_clean", {31'b0, bus.err}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      fill_wbuf(vecs[v].pre);
      run_xact(1'b1, vecs[v].addr, 4'hF, 8, 1'b0);
      fill_wbuf(vecs[v].wdata);
      run_xact(1'b1, vecs[v].addr, vecs[v].be, 8, 1'b0);
      run_xact(1'b0, vecs[v].raddr, 4'h0, 8, 1'b0);
      for (int i = 0; i < 8; i++) begin
`ifdef PMEM_BYTE_ENABLE_EN
        chk("vec_word", rbuf[i], vecs[v].exp_be);
`else
        chk("vec_word", rbuf[i], vecs[v].exp_full);
`endif
      end
    end

    // Both requests at once: refused, sticky error.
    @(negedge clk);
    bus.mem_read    = 1'b1;
    bus.mem_write   = 1'b1;
    bus.mem_address = 32'h0000_0040;
    seen = 0;
    @(negedge clk);
    chk("both_err", {31'b0, bus.err}, 32'd1);
    for (int c = 0; c < LAT + 10; c++) begin
      @(negedge clk);
      if (bus.mem_resp) seen++;
    end
    chk("both_no_resp", 32'(seen), 32'd0);
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    run_xact(1'b0, 32'h0000_0040, 4'h0, 8, 1'b0);
    chk("err_sticky", {31'b0, bus.err}, 32'd1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", {31'b0, bus.err}, 32'd0);

    // Request withdrawn during the latency wait.
    bus.mem_read    = 1'b1;
    bus.mem_address = 32'h0000_0040;
    @(negedge clk);
    bus.mem_read = 1'b0;
    seen = 0;
    for (int c = 0; c < LAT + 10; c++) begin
      @(negedge clk);
      if (bus.mem_resp) seen++;
    end
    chk("wait_abort_resp", 32'(seen), 32'd0);
    chk("wait_abort_err", {31'b0, bus.err}, 32'd1);
    run_xact(1'b0, 32'h0000_0040, 4'h0, 8, 1'b0);
    do_reset();

    // Reset at beat 3 of a write, then a write dropped at beat 5.
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hE000_0000 + 32'(i);
    run_xact(1'b1, 32'h0000_0100, 4'hF, 3, 1'b1);
    run_xact(1'b0, 32'h0000_0100, 4'h0, 8, 1'b0);
    for (int i = 0; i < 8; i++) wbuf[i] = 32'hB000_0000 + 32'(i);
    run_xact(1'b1, 32'h0000_0200, 4'hF, 5, 1'b0);
    run_xact(1'b0, 32'h0000_0200, 4'h0, 8, 1'b0);
    run_xact(1'b0, 32'h0000_0100, 4'h0, 2, 1'b0);
    do_reset();

    for (int n = 0; n < 40; n++) begin
      bit wr;
      wr = 1'($urandom_range(0, 1));
      for (int i = 0; i < 8; i++) wbuf[i] = $urandom;
      run_xact(wr, $urandom, 4'($urandom_range(0, 15)), 8, 1'b0);
    end
    chk("rand_err", {31'b0, bus.err}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
